// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_rom_arbiter_pkg: shared widths, defaults and the read-tag type for the sprite ROM arbiter
package sprite_rom_arbiter_pkg;
  localparam int NREQ_DEF = 4;
  localparam int AW = 5;
  localparam int CW = 12;
  localparam int IW = 3;
  localparam logic [CW-1:0] TRANSP_DEF = 12'h28F;
  typedef struct packed {
    logic          v;
    logic [IW-1:0] idx;
  } tag_t;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester bus plus the shared sprite ROM port
interface sprite_rom_arbiter_if import sprite_rom_arbiter_pkg::*; #(parameter int NREQ = NREQ_DEF);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_row;
  logic [NREQ*AW-1:0] req_col;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_row;
  logic [AW-1:0]      rom_col;
  logic [CW-1:0]      rom_data;
  logic [NREQ-1:0]    rd_valid;
  logic [CW-1:0]      rd_data;
  logic               rd_transp;
  modport slave (
    input  req, req_row, req_col, rom_data,
    output gnt, rom_row, rom_col, rd_valid, rd_data, rd_transp
  );
  modport master (
    output req, req_row, req_col, rom_data,
    input  gnt, rom_row, rom_col, rd_valid, rd_data, rd_transp
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin priority encoder; search starts just after the last winner
module rr_arbiter import sprite_rom_arbiter_pkg::*; #(
  parameter int NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [2*NREQ-1:0] rot;
  int                pos;
  // rot[p] is the request of requester (ptr+1+p) mod NREQ
  always_comb begin
    rot = {req_i, req_i} >> (int'(ptr_q) + 1);
    pos = 0;
    any_o = 1'b0;
    for (int p = NREQ - 1; p >= 0; p--)
      if (rot[p]) begin
        pos = p;
        any_o = reset_n;
      end
    idx_o = any_o ? IW'((int'(ptr_q) + 1 + pos) % NREQ) : ptr_q;
    gnt_o = any_o ? NREQ'(1) << idx_o : '0;
    ptr_d = idx_o;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_q <= IW'(NREQ - 1);
    else ptr_q <= ptr_d;
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one registered-address sprite ROM among NREQ requesters,
// returning each colour two cycles after its grant with a transparency flag.
module sprite_rom_arbiter import sprite_rom_arbiter_pkg::*; #(
  parameter int            NREQ   = NREQ_DEF,
  parameter logic [CW-1:0] TRANSP = TRANSP_DEF
) (
  input logic                clk,
  input logic                reset_n,
  sprite_rom_arbiter_if.slave bus
);
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   idx;
  logic            any;
  logic [AW-1:0]   row_q, row_d, col_q, col_d;
  tag_t            s1_q, s1_d;
  logic [NREQ-1:0] vld_q, vld_d;
  logic [CW-1:0]   data_q, data_d;
  logic            transp_q, transp_d;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req_i  (bus.req),
    .gnt_o  (gnt),
    .idx_o  (idx),
    .any_o  (any)
  );
  // The ROM registers its address itself, so the winner's address goes out in the grant cycle
  always_comb begin
    row_d = any ? AW'(bus.req_row >> (int'(idx) * AW)) : row_q;
    col_d = any ? AW'(bus.req_col >> (int'(idx) * AW)) : col_q;
    s1_d = '{v: any, idx: idx};
    vld_d = s1_q.v ? NREQ'(1) << s1_q.idx : '0;
    data_d = s1_q.v ? bus.rom_data : data_q;
    transp_d = s1_q.v ? (bus.rom_data == TRANSP) : transp_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
      s1_q <= '0;
      vld_q <= '0;
      data_q <= '0;
      transp_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      s1_q <= s1_d;
      vld_q <= vld_d;
      data_q <= data_d;
      transp_q <= transp_d;
    end
  assign bus.gnt = gnt;
  assign bus.rom_row = row_d;
  assign bus.rom_col = col_d;
  assign bus.rd_valid = vld_q;
  assign bus.rd_data = data_q;
  assign bus.rd_transp = transp_q;
endmodule
